data_mem_responder: RTL

- Data-memory responder for the pipelined core. It is the target end of the memory stage's load/store port.
- Accepts one word-oriented request at a time: address, write data, byte enables and write flag.
- Inserts a parameterised number of wait states and holds the pipeline stall high until the response is ready.
- Returns read data in the cycle the memory-stage result is captured into the write-back register.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/dm_bram.sv | 29 ++
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    // Legal byte-enable masks: single bytes, aligned halves, full word.
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // True when the mask is one of the legal shapes and the byte address is
    // aligned for that access size. Single-byte accesses have no alignment rule.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: ok = 1'b1;
            BE_H0, BE_H1:               ok = (addr_lo[0] == 1'b0);
            BE_W:                       ok = (addr_lo == 2'b00);
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the memory stage (master) and the responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, stall, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, stall, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/dm_bram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enable,
// one-cycle read latency (read-before-write on the same address).
module dm_bram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Byte-lane writes and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][i] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Target end of the memory stage's load/store port: accepts one request,
// holds stall through the wait states, and returns a one-cycle response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dm_state_t   state, next_state;
    logic [3:0]  cnt, cnt_nxt;

    // Request captured at acceptance; inputs are ignored afterwards.
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    // Request actually used for the RAM access on the edge entering RESP.
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_fault;

    logic        accept;
    logic        enter_resp;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic        rd_ok_q;
    logic        fault_q;

    assign accept = (state == IDLE) && bus.req_valid;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // before the latch holds the request, so IDLE uses the live inputs.
    always_comb begin
        if (state == IDLE) begin
            sel_we    = bus.req_we;
            sel_addr  = bus.req_addr;
            sel_wdata = bus.req_wdata;
            sel_be    = bus.req_be;
        end else begin
            sel_we    = lat_we;
            sel_addr  = lat_addr;
            sel_wdata = lat_wdata;
            sel_be    = lat_be;
        end
    end

    // Base is aligned to the RAM size, so the range check is a compare of the
    // upper address bits and the word index is just the middle bits.
    always_comb begin
        sel_fault = 1'b0;
        if (sel_addr[31:AW+2] != BASE_ADDR[31:AW+2]) begin
            sel_fault = 1'b1;
        end
        if (!be_legal(sel_be, sel_addr[1:0])) begin
            sel_fault = 1'b1;
        end
    end

    // Reset on the same edge wins, so a pending store never commits.
    assign enter_resp = (next_state == RESP) && (state != RESP) && !reset;
    assign ram_we     = (enter_resp && sel_we && !sel_fault) ? sel_be : 4'b0000;

    dm_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_bram (
        .clk   (clk),
        .en    (enter_resp),
        .we    (ram_we),
        .addr  (sel_addr[AW+1:2]),
        .wdata (sel_wdata),
        .rdata (ram_rdata)
    );

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state    = state;
        cnt_nxt       = cnt;
        bus.req_ready = 1'b0;
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.stall     = bus.req_valid;
                if (bus.req_valid) begin
                    cnt_nxt    = WAIT_INIT;
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                bus.stall = 1'b1;
                cnt_nxt   = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                next_state    = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the request at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
        end
    end

    // Response qualifiers registered alongside the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ok_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (enter_resp) begin
            rd_ok_q <= !sel_we && !sel_fault;
            fault_q <= sel_fault;
        end
    end

    // Data is zero for stores, faults and outside the response cycle.
    assign bus.rsp_rdata = ((state == RESP) && rd_ok_q) ? ram_rdata : 32'd0;
    assign bus.rsp_fault = (state == RESP) && fault_q;

endmodule
